// File: rtl/conv5x5_engine.sv
// 5x5 valid convolution of a 14x14 Q8.8 map into a 10x10 map.
// The output uses bias, truncation, saturation and ReLU; there is one multiply per cycle.
module conv5x5_engine #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter int FRAC_BITS  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic [7:0]                   fmap_addr,
   input  logic signed [DATA_WIDTH-1:0] fmap_dout,
   output logic [4:0]                   w_addr,
   input  logic signed [DATA_WIDTH-1:0] w_dout,
   input  logic signed [DATA_WIDTH-1:0] bias,
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic [6:0]                   out_addr,
   output logic                         busy,
   output logic                         done
);

   localparam int PROD_W = 2 * DATA_WIDTH;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;

   state_t state, state_nxt;
   logic [2:0] kr, kc, kr_n, kc_n;
   logic [3:0] ox, oy, ox_n, oy_n;
   logic       wcnt, wcnt_n;

   logic                         vld_p1, vld_p2;
   logic signed [PROD_W-1:0]     prod_p1;
   logic signed [ACC_WIDTH-1:0]  acc_p2, acc_sum, prod_ext, bias_ext;

   function automatic logic [7:0] tap_faddr(input logic [3:0] py, input logic [3:0] px,
                                            input logic [2:0] ty, input logic [2:0] tx);
      return ({4'd0, py} + {5'd0, ty}) * 8'd14 + {4'd0, px} + {5'd0, tx};
   endfunction

   function automatic logic [4:0] tap_waddr(input logic [2:0] ty, input logic [2:0] tx);
      return {2'd0, ty} * 5'd5 + {2'd0, tx};
   endfunction

   // Truncating shift back to Q8.8, clamp to the word range, then ReLU.
   function automatic logic signed [DATA_WIDTH-1:0] sat_relu(input logic signed [ACC_WIDTH-1:0] a);
      logic signed [ACC_WIDTH-1:0] s;
      logic signed [ACC_WIDTH-1:0] smax;
      s    = a >>> FRAC_BITS;
      smax = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
      if (s[ACC_WIDTH-1])
         return '0;
      else if (s > smax)
         return {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
         return s[DATA_WIDTH-1:0];
   endfunction

   assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
   assign prod_ext = {{(ACC_WIDTH-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};
   assign acc_sum  = acc_p2 + prod_ext;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   always_comb begin
      state_nxt = state;
      kr_n      = kr;
      kc_n      = kc;
      ox_n      = ox;
      oy_n      = oy;
      wcnt_n    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
               kr_n = 3'd0;
               kc_n = 3'd0;
               ox_n = 4'd0;
               oy_n = 4'd0;
            end
         end
         FETCH: begin
            if (kr == 3'd4 && kc == 3'd4) begin
               state_nxt = WAIT;
            end else if (kc == 3'd4) begin
               kr_n = kr + 3'd1;
               kc_n = 3'd0;
            end else begin
               kc_n = kc + 3'd1;
            end
         end
         WAIT: begin
            wcnt_n = ~wcnt;
            if (wcnt) begin
               state_nxt = WRITE;
               wcnt_n    = 1'b0;
            end
         end
         WRITE: begin
            kr_n = 3'd0;
            kc_n = 3'd0;
            if (ox == 4'd9 && oy == 4'd9) begin
               state_nxt = DONE;
            end else begin
               state_nxt = FETCH;
               if (ox == 4'd9) begin
                  ox_n = 4'd0;
                  oy_n = oy + 4'd1;
               end else begin
                  ox_n = ox + 4'd1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // p0: addresses are registered from next-state counters, so they line up with FETCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         kr        <= 3'd0;
         kc        <= 3'd0;
         ox        <= 4'd0;
         oy        <= 4'd0;
         wcnt      <= 1'b0;
         fmap_addr <= 8'd0;
         w_addr    <= 5'd0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         out_valid <= 1'b0;
         out_addr  <= 7'd0;
         out_data  <= '0;
         acc_p2    <= '0;
      end else begin
         state     <= state_nxt;
         kr        <= kr_n;
         kc        <= kc_n;
         ox        <= ox_n;
         oy        <= oy_n;
         wcnt      <= wcnt_n;
         fmap_addr <= (state_nxt == FETCH) ? tap_faddr(oy_n, ox_n, kr_n, kc_n) : 8'd0;
         w_addr    <= (state_nxt == FETCH) ? tap_waddr(kr_n, kc_n) : 5'd0;
         vld_p1    <= (state == FETCH);
         vld_p2    <= vld_p1;
         out_valid <= (state_nxt == WRITE);
         // p2: the final tap is folded in on the same edge that loads the result.
         if (state_nxt == FETCH && state != FETCH)
            acc_p2 <= bias_ext <<< FRAC_BITS;
         else if (vld_p2)
            acc_p2 <= acc_sum;
         if (state_nxt == WRITE) begin
            out_data <= sat_relu(acc_sum);
            out_addr <= {3'd0, oy} * 7'd10 + {3'd0, ox};
         end
      end
   end

   // p1: product of the returned map word and weight.
   always_ff @(posedge clk) begin
      prod_p1 <= fmap_dout * w_dout;
   end

endmodule

// File: tb/tb_conv5x5_engine.sv
// Directed bench for conv5x5_engine: table of uniform/ramp frames checked cycle by cycle,
// plus hand-written sequences for reset state, restart after mid-frame reset.
module tb_conv5x5_engine;

   logic               clk = 1'b0;
   logic               rst, start;
   logic [7:0]         fmap_addr;
   logic signed [15:0] fmap_dout, w_dout, bias;
   logic [4:0]         w_addr;
   logic               out_valid, busy, done;
   logic signed [15:0] out_data;
   logic [6:0]         out_addr;

   logic signed [15:0] fmap_mem [0:255];
   logic signed [15:0] w_mem [0:31];

   int checks = 0;
   int errors = 0;
   logic [6:0]         hold_addr;
   logic signed [15:0] hold_data;

   typedef struct {
      logic signed [15:0] fv;
      logic signed [15:0] wv;
      logic signed [15:0] bv;
      bit                 ramp;
      logic signed [15:0] exp;
      bit                 poke;
   } vec_t;
   vec_t vecs [8];

   conv5x5_engine #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .fmap_addr(fmap_addr), .fmap_dout(fmap_dout),
      .w_addr(w_addr), .w_dout(w_dout), .bias(bias),
      .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      fmap_dout <= fmap_mem[fmap_addr];
      w_dout    <= w_mem[w_addr];
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic signed [15:0] conv_ref(input int p);
      longint acc, s;
      int oy, ox;
      oy  = p / 10;
      ox  = p % 10;
      acc = longint'(bias) * 256;
      for (int kr = 0; kr < 5; kr++)
         for (int kc = 0; kc < 5; kc++)
            acc += longint'(fmap_mem[(oy + kr) * 14 + ox + kc]) * longint'(w_mem[kr * 5 + kc]);
      s = acc >>> 8;
      if (s > 32767) s = 32767;
      if (s < 0) s = 0;
      return 16'(s);
   endfunction

   task automatic load_uniform(input logic signed [15:0] fv, input logic signed [15:0] wv);
      for (int i = 0; i < 256; i++) fmap_mem[i] = (i < 196) ? fv : 16'sh1234;
      for (int k = 0; k < 32; k++) w_mem[k] = (k < 25) ? wv : 16'sh1234;
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 196; i++) fmap_mem[i] = 16'(((i * 37) % 23 - 11) * 40);
      for (int k = 0; k < 25; k++) w_mem[k] = 16'(((k * 7) % 11 - 4) * 30);
   endtask

   // Starts a frame and compares every output every cycle against the expected schedule.
   task automatic run_frame(input int idx, input bit ramp, input logic signed [15:0] expc,
                            input bit poke);
      int p, t, nstrobe, ndone;
      logic [7:0] efa;
      logic [4:0] ewa;
      logic ev, ed, eb;
      nstrobe = 0;
      ndone   = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc <= 2805; cyc++) begin
         if (cyc > 0) begin @(posedge clk); #1; end
         p   = cyc / 28;
         t   = cyc % 28;
         ev  = (p < 100) && (t == 27);
         ed  = (cyc == 2800);
         eb  = (cyc <= 2800);
         efa = 8'd0;
         ewa = 5'd0;
         if (p < 100 && t < 25) begin
            efa = 8'((p / 10 + t / 5) * 14 + p % 10 + t % 5);
            ewa = 5'(t);
         end
         if (ev) begin
            hold_addr = 7'(p);
            hold_data = ramp ? conv_ref(p) : expc;
         end
         if (out_valid) nstrobe++;
         if (done) ndone++;
         check($sformatf("frame%0d_cyc%0d {vld,done,busy,faddr,waddr,oaddr,odata}", idx, cyc),
               64'({out_valid, done, busy, fmap_addr, w_addr, out_addr, out_data}),
               64'({ev, ed, eb, efa, ewa, hold_addr, hold_data}));
         start = (poke && (cyc == 300 || cyc == 2800)) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      check($sformatf("frame%0d_strobe_count", idx), 64'(nstrobe), 64'd100);
      check($sformatf("frame%0d_done_count", idx), 64'(ndone), 64'd1);
   endtask

   initial begin
      int bad;
      vecs[0] = '{16'sd256,   16'sd256,   16'sd0,    1'b0, 16'sd6400,  1'b0};
      vecs[1] = '{16'sd256,   -16'sd256,  16'sd0,    1'b0, 16'sd0,     1'b0};
      vecs[2] = '{16'sh7FFF,  16'sh7FFF,  16'sd0,    1'b0, 16'sh7FFF,  1'b0};
      vecs[3] = '{16'sd0,     16'sd0,     16'sh0180, 1'b0, 16'sh0180,  1'b0};
      vecs[4] = '{16'sd256,   16'sd128,   16'sh0100, 1'b0, 16'sd3456,  1'b1};
      vecs[5] = '{16'sd512,   16'sd64,    -16'sd256, 1'b0, 16'sd2944,  1'b0};
      vecs[6] = '{16'sd3,     16'sd100,   16'sd0,    1'b0, 16'sd29,    1'b0};
      vecs[7] = '{16'sd0,     16'sd0,     16'sh0040, 1'b1, 16'sd0,     1'b0};

      rst   = 1'b1;
      start = 1'b0;
      bias  = 16'sd0;
      load_uniform(16'sd0, 16'sd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      hold_addr = 7'd0;
      hold_data = 16'sd0;
      check("reset_outputs", 64'({out_valid, done, busy, fmap_addr, w_addr, out_addr, out_data}), 64'd0);
      @(posedge clk); #1;
      check("idle_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].ramp) load_ramp();
         else load_uniform(vecs[i].fv, vecs[i].wv);
         bias = vecs[i].bv;
         repeat (2) @(posedge clk);
         #1;
         run_frame(i, vecs[i].ramp, vecs[i].exp, vecs[i].poke);
      end

      // Abort at pixel 37, confirm silence, then restart from pixel 0.
      load_uniform(16'sd256, 16'sd256);
      bias  = 16'sd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (37 * 28 + 10) begin @(posedge clk); #1; end
      check("pre_abort_out_addr", 64'(out_addr), 64'd36);
      check("pre_abort_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_outputs", 64'({out_valid, done, busy, fmap_addr, w_addr, out_addr, out_data}), 64'd0);
      bad = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (out_valid || done || busy) bad++;
      end
      check("post_abort_quiet_cycles", 64'(bad), 64'd0);
      hold_addr = 7'd0;
      hold_data = 16'sd0;
      run_frame(8, 1'b0, 16'sd6400, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
